// File: rtl/pipelined_rca.sv
// pipelined_rca: parametrised, pipelined ripple-carry adder/subtractor.
//
// The WIDTH-bit carry chain is split into STAGE_BITS-wide slices with one
// register stage per slice (NSTG = WIDTH/STAGE_BITS stages). Upper operand
// slices ride along in shrinking skew registers until their stage. Finished
// lower sum slices accumulate in growing de-skew registers, so the whole of
// Sum leaves the last stage together. A single global advance moves every
// stage at once. Bubbles are held in place and are not collapsed.
//
// Optional feature: define PIPE_RCA_OVF_EN to add the signed-overflow port V.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   A, B            operands (WIDTH)
//   C_in, Sub       carry-in / subtract select, captured at accept
//   in_valid        operands valid
//   in_ready        block can accept this cycle (= advance)
//   Sum, C_out      result and carry out of MSB (borrow-free flag on sub)
//   out_valid       Sum/C_out(/V) valid
//   out_ready       consumer accepts this cycle
//   V               signed overflow (only with PIPE_RCA_OVF_EN)

// Combinational W-bit ripple-carry slice.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module pipelined_rca #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4   // WIDTH must be a multiple of this
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             out_valid,
`ifdef PIPE_RCA_OVF_EN
  output logic             V,
`endif
  input  logic             out_ready
);
  localparam int SB   = STAGE_BITS;
  localparam int NSTG = WIDTH / STAGE_BITS;

  logic             adv, accept, c0;
  logic [WIDTH-1:0] bx;
  logic [NSTG-1:0]  vld_pipe;

  // Whole pipeline moves together. An empty output slot always lets it move.
  assign adv      = ~vld_pipe[NSTG-1] | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // Fold the subtract into the operands once at the door. Sub and C_in then
  // travel implicitly as the inverted B slices and the stage-0 carry.
  assign bx = Sub ? ~B : B;
  assign c0 = C_in ^ Sub;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= accept;
      for (int k = 1; k < NSTG; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Stages 0..NSTG-2. Each resolves its slice, forwards the unresolved upper
  // operand bits (ha/hb minus its slice), and grows the completed low sum.
  genvar k;
  for (k = 0; k < NSTG-1; k++) begin : stg
    localparam int HW = WIDTH - k*SB;  // operand bits still unresolved here

    logic [HW-1:0]        ha, hb;
    logic                 ci, co, cy;
    logic [SB-1:0]        s;
    logic [HW-SB-1:0]     a_hi, b_hi;
    logic [(k+1)*SB-1:0]  lo_next, sum_lo;

    if (k == 0) begin : g_src
      assign ha      = A;
      assign hb      = bx;
      assign ci      = c0;
      assign lo_next = s;
    end else begin : g_src
      assign ha      = stg[k-1].a_hi;
      assign hb      = stg[k-1].b_hi;
      assign ci      = stg[k-1].cy;
      assign lo_next = {s, stg[k-1].sum_lo};
    end

    rca_slice #(.W(SB)) u_add (
      .a(ha[SB-1:0]), .b(hb[SB-1:0]), .cin(ci), .s(s), .cout(co)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_hi   <= '0;
        b_hi   <= '0;
        cy     <= 1'b0;
        sum_lo <= '0;
      end else if (adv) begin
        a_hi   <= ha[HW-1:SB];
        b_hi   <= hb[HW-1:SB];
        cy     <= co;
        sum_lo <= lo_next;
      end
    end
  end

  // Final stage: resolves the top slice and registers the full result.
  logic [SB-1:0]    fa, fb, fs;
  logic             fc, fco;
  logic [WIDTH-1:0] f_next, sum_q;
  logic             cout_q;

  if (NSTG == 1) begin : g_last
    assign fa     = A;
    assign fb     = bx;
    assign fc     = c0;
    assign f_next = fs;
  end else begin : g_last
    assign fa     = stg[NSTG-2].a_hi;
    assign fb     = stg[NSTG-2].b_hi;
    assign fc     = stg[NSTG-2].cy;
    assign f_next = {fs, stg[NSTG-2].sum_lo};
  end

  rca_slice #(.W(SB)) u_add_last (
    .a(fa), .b(fb), .cin(fc), .s(fs), .cout(fco)
  );

`ifdef PIPE_RCA_OVF_EN
  // Same-sign operands (after inversion) producing a different-sign result.
  logic v_q;
  logic v_next;
  assign v_next = (fa[SB-1] == fb[SB-1]) & (fs[SB-1] != fa[SB-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef PIPE_RCA_OVF_EN
      v_q    <= 1'b0;
`endif
    end else if (adv) begin
      sum_q  <= f_next;
      cout_q <= fco;
`ifdef PIPE_RCA_OVF_EN
      v_q    <= v_next;
`endif
    end
  end

  assign Sum       = sum_q;
  assign C_out     = cout_q;
  assign out_valid = vld_pipe[NSTG-1];
`ifdef PIPE_RCA_OVF_EN
  assign V         = v_q;
`endif
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca (WIDTH=16, STAGE_BITS=4).
// A result accepted at edge t is expected on the outputs after edge t+3.
module tb_pipelined_rca;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        C_in = 1'b0, Sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, C_out, out_valid;
  logic [15:0] Sum;
`ifdef PIPE_RCA_OVF_EN
  logic        V;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(16), .STAGE_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C_in(C_in), .Sub(Sub),
    .in_valid(in_valid), .in_ready(in_ready), .Sum(Sum), .C_out(C_out),
    .out_valid(out_valid),
`ifdef PIPE_RCA_OVF_EN
    .V(V),
`endif
    .out_ready(out_ready)
  );

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic v);
    A = a; B = b; C_in = ci; Sub = sb; in_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (Sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", Sum); end
    checks++; if (C_out !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", C_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
`ifdef PIPE_RCA_OVF_EN
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", V); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();                       // accepted at this edge (edge 0)
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_early0: got %b want 0", out_valid); end
    tick(); tick();               // edge 2
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_early2: got %b want 0", out_valid); end
    tick();                       // edge 3
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b want 1", out_valid); end
    checks++; if (Sum !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h want 0000", Sum); end
    checks++; if (C_out !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b want 1", C_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1); tick();
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1); tick();
    in_valid = 1'b0;
    tick(); tick();               // edge 3 after first accept
    checks++; if (out_valid !== 1'b1 || Sum !== 16'hFFFE || C_out !== 1'b0) begin
      errors++; $display("FAIL sub_cin0: got v=%b %h c=%b want v=1 fffe c=0", out_valid, Sum, C_out); end
    tick();
    checks++; if (out_valid !== 1'b1 || Sum !== 16'hFFFD || C_out !== 1'b0) begin
      errors++; $display("FAIL sub_cin1: got v=%b %h c=%b want v=1 fffd c=0", out_valid, Sum, C_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h0F0F, 16'hABCD, 16'h1000, 16'h0000};
    logic [15:0] vb [8] = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0001, 16'hF0F0, 16'h1234, 16'h0FFF, 16'h0000};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [8] = '{16'h2345, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hBE01, 16'h0000, 16'h0001};
    logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      logic ev;
      if (cyc < 8) drive(va[cyc], vb[cyc], vc[cyc], vs[cyc], 1'b1);
      else in_valid = 1'b0;
      tick();
      ev = (cyc >= 3 && cyc <= 10);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL stream_valid cyc%0d: got %b want %b", cyc, out_valid, ev); end
      if (ev) begin
        checks++; if (Sum !== es[cyc-3] || C_out !== ec[cyc-3]) begin
          errors++; $display("FAIL stream_op%0d: got %h c=%b want %h c=%b", cyc-3, Sum, C_out, es[cyc-3], ec[cyc-3]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [5] = '{16'h0001, 16'h00FF, 16'hF000, 16'h0010, 16'h4000};
    logic [15:0] vb [5] = '{16'h0002, 16'h0001, 16'h1000, 16'h0001, 16'h4000};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [5] = '{16'h0003, 16'h0100, 16'h0000, 16'h000F, 16'h8001};
    logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int idx = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vc[i], vs[i], 1'b1);
      tick();
    end
    // op0 now on the outputs; stall with op4 pending at the input
    drive(va[4], vb[4], vc[4], vs[4], 1'b1);
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", in_ready); end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || Sum !== 16'h0003 || C_out !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b %h c=%b rdy=%b want v=1 0003 c=0 rdy=0", s, out_valid, Sum, C_out, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++; if (Sum !== es[idx] || C_out !== ec[idx]) begin
          errors++; $display("FAIL bp_drain%0d: got %h c=%b want %h c=%b", idx, Sum, C_out, es[idx], ec[idx]); end
        idx++;
      end
      tick();
      in_valid = 1'b0;
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL bp_count: got %0d results want 5", idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h0001};
    logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        vs [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] es [3] = '{16'h8000, 16'h7FFF, 16'h0002};
    logic        ev [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 3) drive(va[cyc], vb[cyc], 1'b0, vs[cyc], 1'b1);
      else in_valid = 1'b0;
      tick();
      if (cyc >= 3) begin
        checks++; if (out_valid !== 1'b1 || Sum !== es[cyc-3]) begin
          errors++; $display("FAIL ovf_sum%0d: got v=%b %h want v=1 %h", cyc-3, out_valid, Sum, es[cyc-3]); end
`ifdef PIPE_RCA_OVF_EN
        checks++; if (V !== ev[cyc-3]) begin
          errors++; $display("FAIL ovf_v%0d: got %b want %b", cyc-3, V, ev[cyc-3]); end
`else
        if (ev[cyc-3] === 1'bx) $display("note: unexpected overflow table entry");
`endif
      end
    end
  endtask

  task automatic test_reset_flush();
    logic seen = 1'b0;
    out_ready = 1'b1;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1); tick();
    drive(16'h3333, 16'h1111, 1'b0, 1'b0, 1'b1); tick();
    drive(16'h0101, 16'h0101, 1'b0, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || Sum !== 16'h0 || C_out !== 1'b0) begin
      errors++; $display("FAIL flush_out: got v=%b %h c=%b want v=0 0000 c=0", out_valid, Sum, C_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_ghost: got flushed result want none"); end
    drive(16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 4; e++) begin
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== (e == 3)) begin
        errors++; $display("FAIL flush_lat e%0d: got %b want %b", e, out_valid, (e == 3)); end
    end
    checks++; if (Sum !== 16'h0579 || C_out !== 1'b0) begin
      errors++; $display("FAIL flush_new: got %h c=%b want 0579 c=0", Sum, C_out); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_stream();
    test_backpressure();
    test_overflow();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined ripple-carry adder/subtractor. It extends the team's combinational 4-bit ripple-carry adder to WIDTH bits. The carry chain is cut into STAGE_BITS-wide slices, with one register stage per slice, so long adders close timing at one result per clock. A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of STAGE_BITS.
- STAGE_BITS, 4, bits resolved per pipeline stage; NSTG = WIDTH/STAGE_BITS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C_in  input  1  carry-in (add) / borrow-in, inverted (sub).
- Sub  input  1  0 = add, 1 = subtract.
- in_valid  input  1  A/B/C_in/Sub valid.
- in_ready  output  WIDTH-independent 1  block can accept this cycle.
- Sum  output  WIDTH  result.
- C_out  output  1  carry out of MSB.
- out_valid  output  1  Sum/C_out valid.
- out_ready  input  1  consumer accepts this cycle.
- V  output  1  signed overflow; present only with PIPE_RCA_OVF_EN.

## Operation
- Effective operation: Sum/C_out = A + (Sub ? ~B : B) + (C_in ^ Sub).
  - Sub=1, C_in=0 gives A−B.
  - Sub=1, C_in=1 gives A−B−1.
  - For subtraction, C_out=1 means no borrow.
- Stage k (0..NSTG−1) adds slice bits [k·STAGE_BITS +: STAGE_BITS]. Its carry-in is the registered carry from stage k−1; stage 0 uses C_in^Sub.
- Skew registers delay upper operand slices until their stage.
- De-skew registers delay completed lower sum slices so that all of Sum leaves together.
- Each stage holds a valid bit; stage 0's valid bit loads in_valid & in_ready.
- Global advance: adv = ~out_valid | out_ready.
  - When adv=1, every stage shifts one step.
  - When adv=0, all stages hold, including bubbles. Bubbles are not collapsed.
- in_ready = adv (combinational). An input is accepted only when in_valid & in_ready.
- Sub and C_in are captured at accept and travel with the data. Changing either input mid-stream affects only later operations.
- Results emerge in acceptance order; none are dropped or duplicated.

## Timing
- Latency: a result accepted at edge t is on Sum with out_valid=1 after edge t+NSTG−1. With defaults, the result appears in the 4th cycle after the accept cycle (NSTG register stages).
- Throughput: one result per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0:
  - Sum, C_out, V and out_valid hold stable.
  - in_ready=0.
- Output fire and input accept in the same cycle are permitted.
- Reset (rst_n=0 at an edge), clearing every in-flight operation:
  - all stage valid bits 0, all data/carry registers 0.
  - outputs: out_valid=0, Sum=0, C_out=0, V=0.
  - in_ready=1 after the reset edge.
- Wrap-around: Sum is modulo 2^WIDTH; the carry appears only on C_out.

## Configuration
- PIPE_RCA_OVF_EN defined:
  - port V is present.
  - V = (A[MSB] == B'[MSB]) & (Sum[MSB] != A[MSB]), where B' is B after the Sub inversion.
  - V is registered through the same pipeline as Sum, so it is valid exactly when out_valid=1.
- PIPE_RCA_OVF_EN undefined: port V and its logic are absent; all other behaviour is identical.

## Test plan
Defaults WIDTH=16, STAGE_BITS=4 unless stated.
- Add with full carry propagation: A=0xFFFF, B=0x0001, C_in=0, Sub=0, accepted at cycle 0 → out_valid rises after edge 3; Sum=0x0000, C_out=1.
- Subtract: A=0x0005, B=0x0007, Sub=1, C_in=0 → Sum=0xFFFE, C_out=0. With C_in=1 → Sum=0xFFFD.
- Streaming: 8 back-to-back random operations, out_ready=1 → 8 consecutive out_valid cycles, in order, each matching the reference model.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → in_ready=0, outputs stable. On release, the queued results drain with no loss.
- Overflow (macro defined): 0x7FFF+0x0001 → V=1, Sum=0x8000. 0x8000−0x0001 → V=1, Sum=0x7FFF. Repeat with the macro undefined: build has no V port, sums unchanged.
- Reset mid-stream with 3 operations in flight: rst_n=0 for one edge → out_valid=0, Sum=0. None of the flushed results ever appear. A new operation after reset completes with normal latency.
